// File: rtl/nes_int_pkg.sv
// nes_int_pkg: shared types and vector addresses for the NES interrupt controller
package nes_int_pkg;
  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_NMI  = 2'd1,
    K_IRQ  = 2'd2,
    K_RST  = 2'd3
  } int_kind_t;
  typedef enum logic [1:0] {
    ST_RST_PEND = 2'd0,
    ST_IDLE     = 2'd1,
    ST_REQ      = 2'd2,
    ST_SEQ      = 2'd3
  } state_t;
  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;
endpackage

// File: rtl/pulse.sv
// pulse: one-cycle rising-edge detector on a sampled level
module pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  output logic p
);
  logic q;
  // remember last sampled level so a held-high input fires only once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b0;
    else q <= s;
  assign p = s & ~q;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: NES CPU interrupt arbitration (RST > NMI > IRQ) with NMI hijack
module int_ctrl import nes_int_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nmi_src,
  input  logic [1:0]  irq_src,
  input  logic        irq_mask,
  input  logic        boundary,
  input  logic        ack,
  input  logic        vec_fetch,
  input  logic        done,
  output logic        int_req,
  output logic [1:0]  int_kind,
  output logic [15:0] vector,
  output logic        busy
);
  state_t    state, state_n;
  int_kind_t kind, kind_n;
  logic      req_n, nmi_p, nmi_pend, nmi_clr, irq_active;
  pulse u_nmi_edge (.clk(clk), .rst_n(rst_n), .s(nmi_src), .p(nmi_p));
  assign irq_active = (|irq_src) & ~irq_mask;
  assign nmi_clr    = (state == ST_SEQ) & vec_fetch & (kind == K_NMI);
  assign int_kind   = kind;
  assign busy       = state == ST_SEQ;
  assign vector     = kind == K_NMI ? VEC_NMI : kind == K_RST ? VEC_RST : VEC_IRQ;
  // next state, request and kind; an IRQ turns into NMI whenever one is pending and the vector is not being read
  always_comb begin
    state_n = state;
    kind_n  = kind;
    req_n   = 1'b0;
    unique case (state)
      ST_RST_PEND: begin
        kind_n  = K_RST;
        req_n   = ~ack;
        state_n = ack ? ST_SEQ : ST_RST_PEND;
      end
      ST_IDLE:
        if (boundary && (nmi_pend || irq_active)) begin
          state_n = ST_REQ;
          req_n   = 1'b1;
          kind_n  = nmi_pend ? K_NMI : K_IRQ;
        end
      ST_REQ: begin
        kind_n = (kind == K_IRQ && nmi_pend) ? K_NMI : kind;
        if (ack) state_n = ST_SEQ;
        else if (kind == K_IRQ && !irq_active && !nmi_pend) begin
          state_n = ST_IDLE;
          kind_n  = K_NONE;
        end else req_n = 1'b1;
      end
      ST_SEQ:
        if (done) begin
          state_n = ST_IDLE;
          kind_n  = K_NONE;
        end else if (!vec_fetch && kind == K_IRQ && nmi_pend) kind_n = K_NMI;
    endcase
  end
  // state registers; a new NMI edge wins over a coincident clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ST_RST_PEND;
      kind     <= K_NONE;
      int_req  <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      state    <= state_n;
      kind     <= kind_n;
      int_req  <= req_n;
      nmi_pend <= nmi_p | (nmi_pend & ~nmi_clr);
    end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl
module tb_int_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, nmi_src, irq_mask, boundary, ack, vec_fetch, done;
  logic [1:0]  irq_src;
  logic        int_req, busy;
  logic [1:0]  int_kind;
  logic [15:0] vector;
  int errs = 0;
  int total = 0;
  int reqs;
  int_ctrl dut (
    .clk(clk), .rst_n(rst_n), .nmi_src(nmi_src), .irq_src(irq_src),
    .irq_mask(irq_mask), .boundary(boundary), .ack(ack), .vec_fetch(vec_fetch),
    .done(done), .int_req(int_req), .int_kind(int_kind), .vector(vector), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic st(input string tag, input logic r, input logic [1:0] k, input logic b);
    chk({tag, ".req"}, {15'd0, int_req}, {15'd0, r});
    chk({tag, ".kind"}, {14'd0, int_kind}, {14'd0, k});
    chk({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
  endtask
  initial begin
    rst_n = 0; nmi_src = 0; irq_src = 0; irq_mask = 0;
    boundary = 0; ack = 0; vec_fetch = 0; done = 0;
    tick(2);
    st("rst_hold", 0, 0, 0);
    chk("rst_vec", vector, 16'hFFFE);
    // reset sequence
    rst_n = 1;
    tick();
    st("rst_req", 1, 3, 0);
    chk("rst_vec1", vector, 16'hFFFC);
    tick();
    st("rst_req2", 1, 3, 0);
    ack = 1;
    tick();
    st("rst_ack", 0, 3, 1);
    ack = 0;
    tick(3);
    st("rst_seq", 0, 3, 1);
    vec_fetch = 1;
    tick();
    chk("rst_vf_vec", vector, 16'hFFFC);
    vec_fetch = 0; done = 1;
    tick();
    st("rst_done", 0, 0, 0);
    done = 0;
    // held NMI: one sequence only
    nmi_src = 1; boundary = 1;
    tick();
    st("nmi_pend_only", 0, 0, 0);
    tick();
    st("nmi_req", 1, 1, 0);
    chk("nmi_vec", vector, 16'hFFFA);
    boundary = 0; ack = 1;
    tick();
    st("nmi_ack", 0, 1, 1);
    ack = 0; vec_fetch = 1;
    tick();
    vec_fetch = 0; done = 1;
    tick();
    st("nmi_done", 0, 0, 0);
    done = 0;
    reqs = 0;
    for (int i = 0; i < 16; i++) begin
      boundary = (i % 4 == 0);
      tick();
      reqs += int_req;
    end
    chk("nmi_held_noretrig", reqs[15:0], 16'd0);
    nmi_src = 0; boundary = 0;
    tick();
    // IRQ withdrawn before ack
    irq_src = 2'b01; boundary = 1;
    tick();
    st("irq_req", 1, 2, 0);
    chk("irq_vec", vector, 16'hFFFE);
    irq_src = 0; boundary = 0;
    tick();
    st("irq_drop", 0, 0, 0);
    tick();
    st("irq_drop2", 0, 0, 0);
    // NMI hijacks an IRQ sequence
    irq_src = 2'b01; boundary = 1;
    tick();
    st("hj_req", 1, 2, 0);
    boundary = 0; ack = 1;
    tick();
    st("hj_ack", 0, 2, 1);
    ack = 0; irq_src = 0;
    tick();
    nmi_src = 1;
    tick();
    st("hj_pend", 0, 2, 1);
    tick();
    st("hj_up", 0, 1, 1);
    chk("hj_vec", vector, 16'hFFFA);
    vec_fetch = 1;
    tick();
    chk("hj_vf_vec", vector, 16'hFFFA);
    vec_fetch = 0; done = 1;
    tick();
    st("hj_done", 0, 0, 0);
    done = 0; boundary = 1;
    tick();
    st("hj_cleared", 0, 0, 0);
    tick();
    st("hj_cleared2", 0, 0, 0);
    nmi_src = 0; boundary = 0;
    tick();
    // NMI edge on the vec_fetch cycle of an IRQ sequence
    irq_src = 2'b01; boundary = 1;
    tick();
    st("late_req", 1, 2, 0);
    boundary = 0; ack = 1; irq_src = 0;
    tick();
    ack = 0;
    tick();
    vec_fetch = 1; nmi_src = 1;
    tick();
    st("late_vf", 0, 2, 1);
    chk("late_vec", vector, 16'hFFFE);
    vec_fetch = 0; done = 1;
    tick();
    st("late_done", 0, 0, 0);
    done = 0; boundary = 1;
    tick();
    st("late_nmi_req", 1, 1, 0);
    chk("late_nmi_vec", vector, 16'hFFFA);
    boundary = 0; ack = 1;
    tick();
    ack = 0; vec_fetch = 1; done = 1;
    tick();
    st("late_vf_done", 0, 0, 0);
    vec_fetch = 0; done = 0; boundary = 1;
    tick();
    st("late_cleared", 0, 0, 0);
    nmi_src = 0; boundary = 0;
    // masked IRQ
    irq_src = 2'b11; irq_mask = 1; boundary = 1;
    tick(3);
    st("mask_block", 0, 0, 0);
    irq_mask = 0;
    tick();
    st("mask_clear", 1, 2, 0);
    // reset aborts mid-request, then RST outranks a pending NMI
    #2 rst_n = 0;
    #1;
    st("abort", 0, 0, 0);
    irq_src = 0; boundary = 0;
    tick();
    rst_n = 1; nmi_src = 1; boundary = 1;
    tick();
    st("rst_prio", 1, 3, 0);
    tick();
    st("rst_prio2", 1, 3, 0);
    boundary = 0; ack = 1;
    tick();
    st("rst_prio_ack", 0, 3, 1);
    ack = 0; done = 1;
    tick();
    st("rst_prio_done", 0, 0, 0);
    done = 0; boundary = 1;
    tick();
    st("post_rst_nmi", 1, 1, 0);
    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end
endmodule
